// File: rtl/adc_moving_average.sv
// Running mean over the last 2**LOG2_WIN signed ADC samples, delivered through a valid/ready output.
// Sticky overrun flag is raised when an unconsumed mean gets overwritten.
//   state  | meaning
//   S_FILL | window not yet holding WIN samples, no mean published
//   S_RUN  | window full, every accepted sample publishes a mean
module adc_moving_average #(
  parameter int N        = 18,
  parameter int LOG2_WIN = 3
) (
  input  logic                SCLK,
  input  logic                reset,
  input  logic                rx_done_tick,
  input  logic signed [N-1:0] data_in,
  input  logic                flush,
  input  logic                avg_ready,
  output logic signed [N-1:0] avg_out,
  output logic                avg_valid,
  output logic                overrun,
  output logic                win_full
);

  localparam int WIN = 2**LOG2_WIN;
  localparam int AW  = N + LOG2_WIN;
  localparam int CW  = LOG2_WIN + 1;

  typedef enum logic {S_FILL, S_RUN} state_t;

  state_t                 state_q, state_d;
  logic signed [N-1:0]    mem_q [WIN];
  logic [LOG2_WIN-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic signed [AW-1:0]   acc_q, acc_d, acc_sum;
  logic signed [AW-1:0]   data_ext, old_ext;
  logic signed [N-1:0]    avg_out_q, avg_out_d;
  logic                   avg_valid_q, avg_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   accept, publish;

  assign accept   = rx_done_tick & ~flush;
  assign data_ext = {{LOG2_WIN{data_in[N-1]}}, data_in};
  assign old_ext  = {{LOG2_WIN{mem_q[wr_ptr_q][N-1]}}, mem_q[wr_ptr_q]};
  assign acc_sum  = acc_q + data_ext - old_ext;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    avg_out_d   = avg_out_q;
    avg_valid_d = avg_valid_q;
    overrun_d   = overrun_q;
    publish     = 1'b0;
    if (flush) begin
      state_d     = S_FILL;
      wr_ptr_d    = '0;
      cnt_d       = '0;
      acc_d       = '0;
      avg_valid_d = 1'b0;
    end else begin
      if (avg_valid_q && avg_ready) avg_valid_d = 1'b0;
      if (accept) begin
        acc_d    = acc_sum;
        wr_ptr_d = wr_ptr_q + 1'b1;
        case (state_q)
          S_FILL: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIN - 1)) begin
              state_d = S_RUN;
              publish = 1'b1;
            end
          end
          S_RUN:   publish = 1'b1;
          default: state_d = S_FILL;
        endcase
      end
      if (publish) begin
        // Upper N bits of the sum are the arithmetic-shifted (floor) mean
        avg_out_d   = acc_sum[AW-1 -: N];
        avg_valid_d = 1'b1;
        if (avg_valid_q && !avg_ready) overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge SCLK or posedge reset) begin
    if (reset) begin
      state_q     <= S_FILL;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      avg_out_q   <= '0;
      avg_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      avg_out_q   <= avg_out_d;
      avg_valid_q <= avg_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  // Cleared storage lets the fill phase evict zeros with the same update equation
  always_ff @(posedge SCLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIN; i++) mem_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < WIN; i++) mem_q[i] <= '0;
    end else if (accept) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign avg_out   = avg_out_q;
  assign avg_valid = avg_valid_q;
  assign overrun   = overrun_q;
  assign win_full  = (state_q == S_RUN);

endmodule

// File: tb/tb_adc_moving_average.sv
// Directed bench for adc_moving_average: expected means queued at stimulus time,
// a negedge monitor pops and compares on every valid/ready transfer.
module tb_adc_moving_average;
  localparam int N = 18;

  logic                SCLK = 1'b0;
  logic                reset;
  logic                rx_done_tick;
  logic signed [N-1:0] data_in;
  logic                flush;
  logic                avg_ready;
  logic signed [N-1:0] avg_out;
  logic                avg_valid;
  logic                overrun;
  logic                win_full;

  int checks = 0;
  int errors = 0;
  int sb[$];
  int mwin[8];
  int mcnt, mptr, last_mean;

  adc_moving_average #(.N(N), .LOG2_WIN(3)) dut (
    .SCLK(SCLK), .reset(reset), .rx_done_tick(rx_done_tick), .data_in(data_in),
    .flush(flush), .avg_ready(avg_ready), .avg_out(avg_out), .avg_valid(avg_valid),
    .overrun(overrun), .win_full(win_full)
  );

  always #5 SCLK = ~SCLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) mwin[i] = 0;
    mcnt = 0;
    mptr = 0;
  endtask

  // Reference mean: full window sum divided with floor rounding
  task automatic tick(input int val, input bit keep = 1'b1);
    longint s;
    @(posedge SCLK); #1;
    rx_done_tick = 1'b1;
    data_in      = N'(val);
    @(posedge SCLK); #1;
    rx_done_tick = 1'b0;
    mwin[mptr] = val;
    mptr = (mptr + 1) % 8;
    if (mcnt < 8) mcnt++;
    if (mcnt == 8) begin
      s = 0;
      for (int i = 0; i < 8; i++) s += mwin[i];
      last_mean = (s >= 0) ? int'(s / 8) : -int'((-s + 7) / 8);
      if (keep) sb.push_back(last_mean);
      chk("tick_avg_out", int'(avg_out), last_mean);
    end
    chk("tick_avg_valid", int'(avg_valid), int'(mcnt == 8));
    chk("tick_win_full", int'(win_full), int'(mcnt == 8));
  endtask

  task automatic do_reset();
    @(posedge SCLK); #1;
    reset = 1'b1;
    @(posedge SCLK); #1;
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    forever begin
      @(negedge SCLK);
      if (!reset && avg_valid && avg_ready) begin
        int e;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got avg_out=%0d, expected no transfer", avg_out);
        end else begin
          e = sb.pop_front();
          if (int'(avg_out) != e) begin
            errors++;
            $display("FAIL sb_transfer: got %0d, expected %0d", avg_out, e);
          end
        end
      end
    end
  end

  initial begin
    reset        = 1'b1;
    rx_done_tick = 1'b0;
    flush        = 1'b0;
    avg_ready    = 1'b1;
    data_in      = '0;
    last_mean    = 0;
    model_clear();
    repeat (3) @(posedge SCLK);
    #1;
    chk("rst_avg_out", int'(avg_out), 0);
    chk("rst_avg_valid", int'(avg_valid), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_win_full", int'(win_full), 0);
    @(posedge SCLK); #1;
    reset = 1'b0;

    // 1: fill with 100
    for (int i = 0; i < 7; i++) tick(100);
    tick(100);
    chk("t1_avg", int'(avg_out), 100);

    // 2: one 900 replaces a 100
    tick(900);
    chk("t2_avg", int'(avg_out), 200);
    @(posedge SCLK); #1;
    chk("t2_valid_drop", int'(avg_valid), 0);

    // 3: floor rounding and extremes
    do_reset();
    for (int i = 0; i < 7; i++) tick(0);
    tick(-1);
    chk("t3_neg1", int'(avg_out), -1);
    chk("t3_neg1_bits", int'($unsigned(avg_out)), 'h3FFFF);
    for (int i = 0; i < 8; i++) tick(131071);
    chk("t3_max", int'(avg_out), 131071);
    for (int i = 0; i < 8; i++) tick(-131072);
    chk("t3_min", int'(avg_out), -131072);

    // 4: stall, overwrite, then drain
    @(posedge SCLK); #1;
    avg_ready = 1'b0;
    tick(200, 1'b0);
    chk("t4_overrun_pre", int'(overrun), 0);
    tick(200);
    chk("t4_overrun", int'(overrun), 1);
    chk("t4_avg", int'(avg_out), -98254);
    @(posedge SCLK); #1;
    avg_ready = 1'b1;
    @(posedge SCLK); #1;
    chk("t4_valid_drop", int'(avg_valid), 0);
    chk("t4_overrun_sticky", int'(overrun), 1);

    // 5: flush wins over a simultaneous sample
    avg_ready = 1'b0;
    tick(7, 1'b0);
    @(posedge SCLK); #1;
    flush        = 1'b1;
    rx_done_tick = 1'b1;
    data_in      = N'(555);
    @(posedge SCLK); #1;
    flush        = 1'b0;
    rx_done_tick = 1'b0;
    model_clear();
    chk("t5_win_full", int'(win_full), 0);
    chk("t5_valid", int'(avg_valid), 0);
    chk("t5_overrun_kept", int'(overrun), 1);
    avg_ready = 1'b1;
    for (int i = 1; i <= 7; i++) tick(8 * i);
    tick(64);
    chk("t5_avg", int'(avg_out), 36);

    // 6: async reset in the middle of a fill
    @(posedge SCLK); #1;
    flush = 1'b1;
    @(posedge SCLK); #1;
    flush = 1'b0;
    model_clear();
    for (int i = 0; i < 4; i++) tick(1000);
    @(posedge SCLK); #3;
    reset = 1'b1;
    #1;
    chk("t6_rst_avg_out", int'(avg_out), 0);
    chk("t6_rst_overrun", int'(overrun), 0);
    chk("t6_rst_valid", int'(avg_valid), 0);
    chk("t6_rst_win_full", int'(win_full), 0);
    @(posedge SCLK); #1;
    reset = 1'b0;
    model_clear();
    for (int i = 0; i < 8; i++) tick(40);
    chk("t6_avg", int'(avg_out), 40);

    repeat (4) @(posedge SCLK);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
